apb_master: RTL and testbench

//  APB requester. Turns single transfer commands from a local valid/ready

---
 rtl/apb_pkg.sv | 16 +
 rtl/apb_master_if.sv | 33 +++
 rtl/apb_master_timeout.sv | 43 ++++
 rtl/apb_master.sv | 153 +++++++++++++++
 tb/tb_apb_master.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// APB requester shared definitions: FSM state encoding and PPROT bit positions.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        ERR    = 2'd3
    } apb_state_e;

    // Bit positions inside PPROT / cmd_prot
    localparam int PROT_PRIV   = 0;
    localparam int PROT_NONSEC = 1;
    localparam int PROT_INSTR  = 2;

endpackage

// File: rtl/apb_master_if.sv
// APB bus bundle between one requester and its completers.
//   master modport: drives PADDR/PPROT/PSELx/PENABLE/PWRITE/PWDATA/PSTRB,
//                   samples PRDATA/PREADY/PSLVERR
//   slave modport : the reverse view
interface apb_master_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 4
);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] PADDR;
    logic [2:0]            PPROT;
    logic [NUM_SLAVES-1:0] PSELx;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [STRB_W-1:0]     PSTRB;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PADDR, PPROT, PSELx, PENABLE, PWRITE, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PPROT, PSELx, PENABLE, PWRITE, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_master_timeout.sv
// Wait-state counter for the APB access phase.
//   PCLK, PRESETn : clock, async active-low reset
//   clear         : zero the count (asserted the cycle before ACCESS)
//   enable        : count this cycle (ACCESS with PREADY low)
//   expired       : this enabled cycle is wait cycle number TIMEOUT_CYCLES
// TIMEOUT_CYCLES = 0 disables the timeout entirely.
module apb_master_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
            logic [CNT_W-1:0] cnt;

            // Saturates at LIMIT instead of wrapping back to zero.
            always_ff @(posedge PCLK or negedge PRESETn) begin
                if (!PRESETn) begin
                    cnt <= '0;
                end else if (clear) begin
                    cnt <= '0;
                end else if (enable && (cnt != LIMIT)) begin
                    cnt <= cnt + 1'b1;
                end
            end

            // Flags the edge on which the count would reach LIMIT, so the
            // abort lands exactly after TIMEOUT_CYCLES wait cycles.
            assign expired = enable && (cnt == LIMIT - 1'b1);
        end else begin : g_no_timeout
            assign expired = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/apb_master.sv
// APB requester: converts single valid/ready commands into APB SETUP/ACCESS
// transfers and returns one response pulse per command.
//   PCLK, PRESETn      : clock, async active-low reset
//   cmd_valid/ready    : command handshake (ready registered, high only in IDLE)
//   cmd_write/addr/wdata/strb/prot : transfer attributes
//   rsp_valid          : one-cycle response pulse
//   rsp_rdata          : read data, 0 on write or error
//   rsp_err            : PSLVERR, misaligned address or timeout
//   rsp_timeout        : error caused by wait-state timeout
//   apb (master)       : APB bus toward NUM_SLAVES completers
//
// state  | meaning
// IDLE   | waiting for a command
// SETUP  | PSELx asserted, PENABLE low
// ACCESS | PENABLE high, waiting for PREADY or timeout
// ERR    | misaligned command rejected, response already issued
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    apb_master_if.master            apb
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int SEL_W  = $clog2(NUM_SLAVES);

    apb_state_e            state;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [2:0]            pprot_q;
    logic [NUM_SLAVES-1:0] psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [STRB_W-1:0]     pstrb_q;
    logic                  to_expired;

    apb_master_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .clear   (state == SETUP),
        .enable  ((state == ACCESS) && !apb.PREADY),
        .expired (to_expired)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            paddr_q     <= '0;
            pprot_q     <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
        end else begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;

            case (state)
                IDLE: begin
                    // cmd_ready rises one cycle after entering IDLE, which keeps
                    // it low during the rsp_valid pulse.
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (cmd_addr[1:0] != 2'b00) begin
                            state     <= ERR;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            state    <= SETUP;
                            paddr_q  <= cmd_addr;
                            pprot_q  <= cmd_prot;
                            pwrite_q <= cmd_write;
                            pwdata_q <= cmd_write ? cmd_wdata : '0;
                            pstrb_q  <= cmd_write ? cmd_strb : '0;
                            psel_q   <= NUM_SLAVES'(1) << cmd_addr[ADDR_WIDTH-1 -: SEL_W];
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end

                SETUP: begin
                    state     <= ACCESS;
                    penable_q <= 1'b1;
                end

                ACCESS: begin
                    // A PREADY arriving on the timeout edge still completes normally.
                    if (apb.PREADY) begin
                        state     <= IDLE;
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= apb.PSLVERR;
                        rsp_rdata <= (!pwrite_q && !apb.PSLVERR) ? apb.PRDATA : '0;
                    end else if (to_expired) begin
                        state       <= IDLE;
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end
                end

                ERR: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign apb.PADDR   = paddr_q;
    assign apb.PPROT   = pprot_q;
    assign apb.PSELx   = psel_q;
    assign apb.PENABLE = penable_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PWDATA  = pwdata_q;
    assign apb.PSTRB   = pstrb_q;

endmodule

// File: tb/tb_apb_master.sv
module tb_apb_master;
    import apb_pkg::*;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic [2:0]  cmd_prot = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;

    int checks = 0;
    int errors = 0;
    int wait_n = 0;
    int acc_cnt = 0;

    // expected response: {timeout, err, rdata}
    logic [33:0] exp_q[$];

    apb_master_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .NUM_SLAVES(4)) apb ();

    apb_master #(
        .ADDR_WIDTH     (16),
        .DATA_WIDTH     (32),
        .NUM_SLAVES     (4),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .cmd_prot    (cmd_prot),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .apb         (apb.master)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Completer model: PREADY rises after wait_n ACCESS cycles.
    initial begin
        apb.PREADY  = 1'b0;
        apb.PRDATA  = '0;
        apb.PSLVERR = 1'b0;
        forever begin
            @(negedge PCLK);
            if (apb.PENABLE === 1'b1) begin
                apb.PREADY = (acc_cnt >= wait_n);
                acc_cnt++;
            end else begin
                acc_cnt = 0;
                apb.PREADY = 1'b0;
            end
        end
    end

    // Scoreboard monitor
    initial begin
        logic [33:0] e;
        forever begin
            @(negedge PCLK);
            if (rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected actual rsp_valid=1 required no response");
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e[31:0]);
                    chk("rsp_err", 32'(rsp_err), 32'(e[32]));
                    chk("rsp_timeout", 32'(rsp_timeout), 32'(e[33]));
                end
            end
        end
    end

    // Drives one command; returns at the negedge of the cycle after accept.
    task automatic issue(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                         input logic [3:0] st, input logic [2:0] pr, input bit push,
                         input logic [31:0] er, input logic ee, input logic et);
        int n = 0;
        @(negedge PCLK);
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge PCLK);
            n++;
        end
        if (cmd_ready !== 1'b1) chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = wd;
        cmd_strb  = st;
        cmd_prot  = pr;
        cmd_valid = 1'b1;
        if (push) exp_q.push_back({et, ee, er});
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 1'b0;
    endtask

    task automatic count_access(output int acc);
        acc = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge PCLK);
            if (apb.PENABLE === 1'b1) acc++;
            else if (acc > 0) break;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        logic [2:0] prot_a;
        prot_a = 3'b000;
        prot_a[PROT_PRIV]  = 1'b1;
        prot_a[PROT_INSTR] = 1'b1;

        // Reset state
        repeat (3) @(negedge PCLK);
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_psel", 32'(apb.PSELx), 0);
        chk("rst_penable", 32'(apb.PENABLE), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("rst_release_ready", 32'(cmd_ready), 1);

        // 1: write, zero wait states, exact phase timing
        wait_n = 0;
        issue(1'b1, 16'h4010, 32'hCAFEF00D, 4'hF, prot_a, 1'b1, 32'h0, 1'b0, 1'b0);
        chk("t1_setup_psel", 32'(apb.PSELx), 32'b0010);
        chk("t1_setup_penable", 32'(apb.PENABLE), 0);
        chk("t1_paddr", 32'(apb.PADDR), 32'h4010);
        chk("t1_pwdata", apb.PWDATA, 32'hCAFEF00D);
        chk("t1_pstrb", 32'(apb.PSTRB), 32'hF);
        chk("t1_pwrite", 32'(apb.PWRITE), 1);
        chk("t1_pprot", 32'(apb.PPROT), 32'b101);
        chk("t1_ready_busy", 32'(cmd_ready), 0);
        @(negedge PCLK);
        chk("t1_access_penable", 32'(apb.PENABLE), 1);
        chk("t1_access_psel", 32'(apb.PSELx), 32'b0010);
        @(negedge PCLK);
        chk("t1_rsp_valid", 32'(rsp_valid), 1);
        chk("t1_done_psel", 32'(apb.PSELx), 0);
        chk("t1_done_penable", 32'(apb.PENABLE), 0);
        chk("t1_ready_during_rsp", 32'(cmd_ready), 0);
        @(negedge PCLK);
        chk("t1_ready_after_rsp", 32'(cmd_ready), 1);
        chk("t1_paddr_hold", 32'(apb.PADDR), 32'h4010);

        // 2: read with 3 wait states
        wait_n = 3;
        apb.PRDATA = 32'h12345678;
        issue(1'b0, 16'hC004, 32'hFFFF0000, 4'hF, 3'b000, 1'b1, 32'h12345678, 1'b0, 1'b0);
        chk("t2_psel", 32'(apb.PSELx), 32'b1000);
        chk("t2_pstrb", 32'(apb.PSTRB), 0);
        chk("t2_pwdata", apb.PWDATA, 0);
        chk("t2_pwrite", 32'(apb.PWRITE), 0);
        count_access(acc);
        chk("t2_access_len", 32'(acc), 4);

        // 3: write and read completed with PSLVERR
        wait_n = 1;
        apb.PSLVERR = 1'b1;
        apb.PRDATA = 32'hDEADBEEF;
        issue(1'b1, 16'h0008, 32'h11223344, 4'h3, 3'b010, 1'b1, 32'h0, 1'b1, 1'b0);
        chk("t3_psel", 32'(apb.PSELx), 32'b0001);
        count_access(acc);
        issue(1'b0, 16'h8000, 32'h0, 4'h0, 3'b000, 1'b1, 32'h0, 1'b1, 1'b0);
        chk("t3b_psel", 32'(apb.PSELx), 32'b0100);
        count_access(acc);
        apb.PSLVERR = 1'b0;

        // 4: misaligned read, immediate error and no bus activity
        issue(1'b0, 16'h0006, 32'h0, 4'h0, 3'b000, 1'b1, 32'h0, 1'b1, 1'b0);
        chk("t4_rsp_valid", 32'(rsp_valid), 1);
        chk("t4_psel", 32'(apb.PSELx), 0);
        chk("t4_ready", 32'(cmd_ready), 0);
        @(negedge PCLK);
        chk("t4_psel_next", 32'(apb.PSELx), 0);
        chk("t4_ready_next", 32'(cmd_ready), 1);

        // 5: timeout after 4 wait cycles, then a normal transfer
        wait_n = 99;
        apb.PRDATA = 32'h00000055;
        issue(1'b0, 16'h4000, 32'h0, 4'h0, 3'b000, 1'b1, 32'h0, 1'b1, 1'b1);
        count_access(acc);
        chk("t5_access_len", 32'(acc), 4);
        chk("t5_psel_abort", 32'(apb.PSELx), 0);
        wait_n = 0;
        issue(1'b0, 16'h4004, 32'h0, 4'h0, 3'b000, 1'b1, 32'h00000055, 1'b0, 1'b0);
        chk("t5_next_psel", 32'(apb.PSELx), 32'b0010);
        count_access(acc);
        chk("t5_next_access_len", 32'(acc), 1);

        // 6: reset during ACCESS
        wait_n = 99;
        issue(1'b1, 16'h8010, 32'hA5A5A5A5, 4'hF, 3'b111, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge PCLK);
        chk("t6_in_access", 32'(apb.PENABLE), 1);
        #2 PRESETn = 1'b0;
        #1;
        chk("t6_rst_psel", 32'(apb.PSELx), 0);
        chk("t6_rst_penable", 32'(apb.PENABLE), 0);
        chk("t6_rst_paddr", 32'(apb.PADDR), 0);
        chk("t6_rst_pwdata", apb.PWDATA, 0);
        chk("t6_rst_ready", 32'(cmd_ready), 0);
        repeat (2) @(negedge PCLK);
        wait_n = 0;
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("t6_ready_after_release", 32'(cmd_ready), 1);

        repeat (5) @(negedge PCLK);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
